// File: rtl/memwb_pipe_stage.sv
// MEM/WB pipeline stage: holds memory-stage results behind a valid/ready handshake.
// A 2-entry skid buffer absorbs WB back-pressure; the write-back value is selected when an entry is captured.
module memwb_pipe_stage #(
   parameter  int DATA_W  = 16,
   parameter  int RADDR_W = 4,
   parameter  int BYTE_W  = 8,
   localparam int NLANE   = DATA_W / BYTE_W,
   localparam int BSEL_W  = (NLANE > 1) ? $clog2(NLANE) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   input  logic               regWrite,
   input  logic               R15Write,
   input  logic               MemtoReg,
   input  logic               loadByte,
   input  logic               loadSigned,
   input  logic [BSEL_W-1:0]  byteSel,
   input  logic [DATA_W-1:0]  readData_IN,
   input  logic [DATA_W-1:0]  res_IN,
   input  logic [DATA_W-1:0]  R15_in,
   input  logic [RADDR_W-1:0] regDes_IN,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               regWriteOUT,
   output logic               R15WriteOUT,
   output logic               MemtoRegOUT,
   output logic               loadByteOUT,
   output logic [DATA_W-1:0]  readData_OUT,
   output logic [DATA_W-1:0]  res_OUT,
   output logic [DATA_W-1:0]  R15_OUT,
   output logic [RADDR_W-1:0] regDes_OUT,
   output logic [DATA_W-1:0]  wbData
);

   typedef struct packed {
      logic               rw;
      logic               r15w;
      logic               m2r;
      logic               lb;
      logic [DATA_W-1:0]  rd;
      logic [DATA_W-1:0]  res;
      logic [DATA_W-1:0]  r15;
      logic [DATA_W-1:0]  wb;
      logic [RADDR_W-1:0] rdes;
   } ent_t;

   ent_t              h_q, h_d, s_q, s_d, in_ent;
   logic              h_vld_q, h_vld_d, s_vld_q, s_vld_d;
   logic              in_ready_q, in_ready_d;
   logic              acc, pop;
   logic [BYTE_W-1:0] lane;
   logic [DATA_W-1:0] ext, wb_sel;

   // Byte lane extraction and extension, resolved once at capture.
   always_comb begin
      lane = '0;
      for (int i = 0; i < NLANE; i++)
         if (byteSel == BSEL_W'(i)) lane = readData_IN[i*BYTE_W +: BYTE_W];
      ext = '0;
      ext[BYTE_W-1:0] = lane;
      if (loadSigned)
         for (int j = BYTE_W; j < DATA_W; j++) ext[j] = lane[BYTE_W-1];
      wb_sel = !MemtoReg ? res_IN : (loadByte ? ext : readData_IN);
      in_ent = '{rw: regWrite, r15w: R15Write, m2r: MemtoReg, lb: loadByte,
                 rd: readData_IN, res: res_IN, r15: R15_in, wb: wb_sel,
                 rdes: regDes_IN};
   end

   assign acc = in_valid & in_ready_q;
   assign pop = h_vld_q & out_ready;

   always_comb begin
      h_d     = h_q;
      s_d     = s_q;
      h_vld_d = h_vld_q;
      s_vld_d = s_vld_q;
      if (flush) begin
         h_vld_d = 1'b0;
         s_vld_d = 1'b0;
      end else if (s_vld_q) begin
         // FULL: in_ready is low, so only a pop can move state; S drains into H.
         if (pop) begin
            h_d     = s_q;
            s_vld_d = 1'b0;
         end
      end else if (h_vld_q) begin
         case ({acc, pop})
            2'b11:   h_d = in_ent;
            2'b10: begin
               s_d     = in_ent;
               s_vld_d = 1'b1;
            end
            2'b01:   h_vld_d = 1'b0;
            default: ;
         endcase
      end else if (acc) begin
         h_d     = in_ent;
         h_vld_d = 1'b1;
      end
      in_ready_d = !s_vld_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_q        <= '0;
         s_q        <= '0;
         h_vld_q    <= 1'b0;
         s_vld_q    <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         h_q        <= h_d;
         s_q        <= s_d;
         h_vld_q    <= h_vld_d;
         s_vld_q    <= s_vld_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = h_vld_q;
   assign regWriteOUT  = h_q.rw   & h_vld_q;
   assign R15WriteOUT  = h_q.r15w & h_vld_q;
   assign MemtoRegOUT  = h_q.m2r  & h_vld_q;
   assign loadByteOUT  = h_q.lb   & h_vld_q;
   assign readData_OUT = h_q.rd;
   assign res_OUT      = h_q.res;
   assign R15_OUT      = h_q.r15;
   assign regDes_OUT   = h_q.rdes;
   assign wbData       = h_q.wb;

endmodule

// File: tb/tb_memwb_pipe_stage.sv
// Directed bench for memwb_pipe_stage: reset, byte loads, back-pressure, flush, streaming, async reset.
module tb_memwb_pipe_stage;
   logic        clk = 1'b0, rst = 1'b0;
   logic        in_valid, in_ready, flush;
   logic        regWrite, R15Write, MemtoReg, loadByte, loadSigned;
   logic [0:0]  byteSel;
   logic [15:0] readData_IN, res_IN, R15_in;
   logic [3:0]  regDes_IN;
   logic        out_valid, out_ready;
   logic        regWriteOUT, R15WriteOUT, MemtoRegOUT, loadByteOUT;
   logic [15:0] readData_OUT, res_OUT, R15_OUT, wbData;
   logic [3:0]  regDes_OUT;
   int          total = 0, bad = 0;

   memwb_pipe_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .regWrite(regWrite), .R15Write(R15Write), .MemtoReg(MemtoReg), .loadByte(loadByte),
      .loadSigned(loadSigned), .byteSel(byteSel), .readData_IN(readData_IN), .res_IN(res_IN),
      .R15_in(R15_in), .regDes_IN(regDes_IN), .out_valid(out_valid), .out_ready(out_ready),
      .regWriteOUT(regWriteOUT), .R15WriteOUT(R15WriteOUT), .MemtoRegOUT(MemtoRegOUT),
      .loadByteOUT(loadByteOUT), .readData_OUT(readData_OUT), .res_OUT(res_OUT),
      .R15_OUT(R15_OUT), .regDes_OUT(regDes_OUT), .wbData(wbData)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic alu(input logic v, input logic [15:0] r, input logic [3:0] d);
      in_valid = v; regWrite = 1'b1; MemtoReg = 1'b0; loadByte = 1'b0; loadSigned = 1'b0;
      byteSel = 1'b0; res_IN = r; regDes_IN = d; readData_IN = 16'h0; R15_in = 16'h0;
   endtask

   task automatic ld(input logic lb, input logic ls, input logic bs, input logic [15:0] rd);
      in_valid = 1'b1; regWrite = 1'b1; MemtoReg = 1'b1; loadByte = lb; loadSigned = ls;
      byteSel = bs; readData_IN = rd; res_IN = 16'h1234; regDes_IN = 4'd2;
   endtask

   initial begin
      flush = 1'b0; out_ready = 1'b0; R15Write = 1'b0;
      alu(1'b0, 16'h0, 4'd0);
      // 1. reset and single transfer
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_regWriteOUT", regWriteOUT, 0);
      chk("rst_wbData", wbData, 0);
      chk("rst_regDes", regDes_OUT, 0);
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst = 1'b1;
      cyc();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);
      alu(1'b1, 16'h0100, 4'd4);
      out_ready = 1'b1;
      cyc();
      chk("t1_out_valid", out_valid, 1);
      chk("t1_wbData", wbData, 16'h0100);
      chk("t1_regDes", regDes_OUT, 4);
      chk("t1_regWriteOUT", regWriteOUT, 1);
      chk("t1_MemtoRegOUT", MemtoRegOUT, 0);

      // 2. byte load extension, streamed
      ld(1'b1, 1'b0, 1'b0, 16'h80F3); cyc();
      chk("bl_zx_lo", wbData, 16'h00F3);
      chk("bl_loadByteOUT", loadByteOUT, 1);
      chk("bl_readData_OUT", readData_OUT, 16'h80F3);
      ld(1'b1, 1'b1, 1'b0, 16'h80F3); cyc();
      chk("bl_sx_lo", wbData, 16'hFFF3);
      ld(1'b1, 1'b1, 1'b1, 16'h80F3); cyc();
      chk("bl_sx_hi", wbData, 16'hFF80);
      ld(1'b1, 1'b0, 1'b1, 16'h80F3); cyc();
      chk("bl_zx_hi", wbData, 16'h0080);
      ld(1'b0, 1'b1, 1'b1, 16'h80F3); cyc();
      chk("word_load", wbData, 16'h80F3);
      chk("word_res_OUT", res_OUT, 16'h1234);
      in_valid = 1'b0; cyc();
      chk("bl_drain_valid", out_valid, 0);
      chk("bl_drain_rw_gated", regWriteOUT, 0);

      // 3. back-pressure
      out_ready = 1'b0;
      alu(1'b1, 16'h0011, 4'd1); cyc();
      chk("bp_A_head", wbData, 16'h0011);
      chk("bp_one_in_ready", in_ready, 1);
      alu(1'b1, 16'h0022, 4'd2); cyc();
      chk("bp_full_in_ready", in_ready, 0);
      chk("bp_full_head", wbData, 16'h0011);
      alu(1'b1, 16'h0044, 4'd3); cyc();
      chk("bp_C_held_head", wbData, 16'h0011);
      chk("bp_C_held_ready", in_ready, 0);
      out_ready = 1'b1; cyc();
      chk("bp_out_A_then_B", wbData, 16'h0022);
      chk("bp_B_valid", out_valid, 1);
      cyc();
      chk("bp_out_C", wbData, 16'h0044);
      chk("bp_C_regDes", regDes_OUT, 3);
      in_valid = 1'b0; cyc();
      chk("bp_empty", out_valid, 0);

      // 4. flush in FULL, then flush with an accepted input in ONE
      out_ready = 1'b0;
      alu(1'b1, 16'h0055, 4'd5); cyc();
      alu(1'b1, 16'h0066, 4'd6); cyc();
      chk("fl_full", in_ready, 0);
      alu(1'b1, 16'h0033, 4'd7); flush = 1'b1; cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", out_valid, 0);
      chk("fl_rw_gated", regWriteOUT, 0);
      chk("fl_in_ready", in_ready, 1);
      chk("fl_data_hold", wbData, 16'h0055);
      alu(1'b1, 16'h0099, 4'd9); cyc();
      chk("fl1_head", wbData, 16'h0099);
      alu(1'b1, 16'h0033, 4'd7); flush = 1'b1; cyc();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("fl1_valid", out_valid, 0);
      cyc();
      chk("fl_D_never", out_valid, 0);

      // 5. streaming
      for (int i = 1; i <= 8; i++) begin
         alu(1'b1, 16'(i), 4'd8); cyc();
         chk("st_valid", out_valid, 1);
         chk("st_data", wbData, i);
         chk("st_in_ready", in_ready, 1);
      end
      in_valid = 1'b0; cyc();
      chk("st_drain", out_valid, 0);

      // 6. asynchronous reset while FULL
      out_ready = 1'b0;
      alu(1'b1, 16'h0077, 4'd10); cyc();
      alu(1'b1, 16'h0088, 4'd11); cyc();
      in_valid = 1'b0;
      chk("ar_full", in_ready, 0);
      chk("ar_head", wbData, 16'h0077);
      #2 rst = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_wbData", wbData, 0);
      chk("ar_regDes", regDes_OUT, 0);
      chk("ar_rw", regWriteOUT, 0);
      @(negedge clk); rst = 1'b1;
      cyc();
      chk("ar_recover_ready", in_ready, 1);
      chk("ar_recover_valid", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
